// File: rtl/sha256_pad_stream_if.sv
// Handshake bundle shared by message assembly, the SHA-256 padder and the compression pipeline.
// The slave modport is the padder's view; the master modport is the surrounding logic's view.
interface sha256_pad_stream_if #(
    parameter int MAX_BYTES = 1248,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
);
    localparam int MAX_BLK = (MAX_BYTES + 8) / 64 + 1;
    localparam int IDX_W   = $clog2(MAX_BLK);

    logic                   in_valid;
    logic                   in_ready;
    logic [LEN_W-1:0]       in_len;
    logic [8*MAX_BYTES-1:0] in_msg;
    logic                   out_valid;
    logic                   out_ready;
    logic [511:0]           out_block;
    logic                   out_first;
    logic                   out_last;
    logic [IDX_W-1:0]       out_idx;
    logic [IDX_W:0]         out_nblk;
    logic                   len_err;

    modport master (
        output in_valid, in_len, in_msg, out_ready,
        input  in_ready, out_valid, out_block, out_first, out_last, out_idx, out_nblk, len_err
    );

    modport slave (
        input  in_valid, in_len, in_msg, out_ready,
        output in_ready, out_valid, out_block, out_first, out_last, out_idx, out_nblk, len_err
    );
endinterface

// File: rtl/sha256_pad_stream.sv
// SHA-256 message padder: captures one length-tagged message and streams its padded
// 512-bit blocks with first/last/index tags, back-pressured on both sides.
module sha256_pad_stream #(
    parameter int MAX_BYTES = 1248,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sha256_pad_stream_if.slave       bus
);
    localparam int MAX_BLK = (MAX_BYTES + 8) / 64 + 1;
    localparam int IDX_W   = $clog2(MAX_BLK);
    localparam int MSG_W   = 8 * MAX_BYTES;
    localparam int EXT_W   = 512 * MAX_BLK;

    typedef enum logic {IDLE, EMIT} state_e;

    state_e           state_q, state_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W:0]   nblk_q, nblk_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [511:0]     block_q, block_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic             capture, is_last, over_len;
    logic [LEN_W-1:0] sat_len;
    logic [IDX_W:0]   cap_nblk;

    logic [MSG_W-1:0] src_msg;
    logic [LEN_W-1:0] src_len;
    logic [IDX_W:0]   src_nblk;
    logic [IDX_W-1:0] sel_idx;
    logic [EXT_W-1:0] src_ext;
    logic [511:0]     raw_blk, gen_blk;
    logic [63:0]      bit_len;
    int               base_byte, len_pos;

    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out_block = block_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_nblk  = nblk_q;
    assign bus.len_err   = err_q;

    assign capture  = bus.in_valid && bus.in_ready;
    assign over_len = bus.in_len > LEN_W'(MAX_BYTES);
    assign sat_len  = over_len ? LEN_W'(MAX_BYTES) : bus.in_len;
    assign cap_nblk = (IDX_W+1)'((int'(sat_len) + 8) / 64 + 1);
    assign is_last  = ({1'b0, idx_q} == nblk_q - 1'b1);

    // Block generator source: the incoming message at capture, otherwise the stored one.
    always_comb begin
        src_msg  = msg_q;
        src_len  = len_q;
        src_nblk = nblk_q;
        sel_idx  = idx_q + 1'b1;
        if (capture) begin
            src_msg  = bus.in_msg;
            src_len  = sat_len;
            src_nblk = cap_nblk;
            sel_idx  = '0;
        end
    end

    // Message bytes pass below L, 0x80 lands at L, the bit length fills the last 8 bytes.
    always_comb begin
        src_ext   = {src_msg, {(EXT_W-MSG_W){1'b0}}};
        raw_blk   = src_ext[EXT_W-1-512*int'(sel_idx) -: 512];
        bit_len   = {{(64-LEN_W-3){1'b0}}, src_len, 3'b000};
        base_byte = 64 * int'(sel_idx);
        len_pos   = 64 * int'(src_nblk) - 8;
        gen_blk   = '0;
        for (int j = 0; j < 64; j++) begin
            if (base_byte + j < int'(src_len))
                gen_blk[511-8*j -: 8] = raw_blk[511-8*j -: 8];
            else if (base_byte + j == int'(src_len))
                gen_blk[511-8*j -: 8] = 8'h80;
            else if (base_byte + j >= len_pos)
                gen_blk[511-8*j -: 8] = bit_len[63-8*(base_byte+j-len_pos) -: 8];
        end
    end

    always_comb begin
        // NOTE: every _d takes a hold/default value first, so no path leaves one unassigned (no latch).
        state_d = state_q;
        msg_d   = msg_q;
        len_d   = len_q;
        nblk_d  = nblk_q;
        idx_d   = idx_q;
        block_d = block_q;
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = EMIT;
                    msg_d   = bus.in_msg;
                    len_d   = sat_len;
                    nblk_d  = cap_nblk;
                    idx_d   = '0;
                    block_d = gen_blk;
                    valid_d = 1'b1;
                    first_d = 1'b1;
                    last_d  = (cap_nblk == (IDX_W+1)'(1));
                    err_d   = over_len;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        block_d = gen_blk;
                        first_d = 1'b0;
                        last_d  = ({1'b0, idx_q} + (IDX_W+1)'(2) == nblk_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nblk_q  <= '0;
            idx_q   <= '0;
            block_q <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nblk_q  <= nblk_d;
            idx_q   <= idx_d;
            block_q <= block_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // NOTE: message storage is left unreset; it is only read after a capture has overwritten it.
    always_ff @(posedge clk) begin
        msg_q <= msg_d;
        len_q <= len_d;
    end
endmodule

// File: doc/sha256_pad_stream.md
# sha256_pad_stream

Parametrised SHA-256 message padder that accepts a byte-length-tagged message of up to `MAX_BYTES` bytes and emits the FIPS 180-4 padded result as a stream of 512-bit blocks, one block per output handshake. It sits between the node-data assembly logic and the message-schedule/compression pipeline. It replaces fixed-length, single-shot padding with exact padding for any length from 0 to `MAX_BYTES`, block sequencing with first/last/index tags, and back-pressure on both sides.

## Interface
- `MAX_BYTES`, default 1248: maximum message length in bytes; sets the `in_msg` width.
- `LEN_W`, default `$clog2(MAX_BYTES+1)`: width of `in_len`.
- `MAX_BLK`, derived as `(MAX_BYTES+8)/64 + 1`: maximum number of blocks (20 at the default). Not overridable.
- `IDX_W`, derived as `$clog2(MAX_BLK)`: width of the block index.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: message offer.
- `in_ready`, out, 1: block is idle and can capture a message.
- `in_len`, in, LEN_W: message length in bytes.
- `in_msg`, in, 8*MAX_BYTES: message bytes, left-aligned. Byte 0 is `in_msg[8*MAX_BYTES-1 -: 8]`; bytes at index ≥ `in_len` are don't-care.
- `out_valid`, out, 1: `out_block` is valid.
- `out_ready`, in, 1: downstream accepts the block.
- `out_block`, out, 512: padded block, big-endian. Byte 0 is `[511:504]`.
- `out_first`, out, 1: the current block is block 0.
- `out_last`, out, 1: the current block is the final block.
- `out_idx`, out, IDX_W: index of the current block.
- `out_nblk`, out, IDX_W+1: total block count for this message.
- `len_err`, out, 1: one-cycle pulse when a message with `in_len > MAX_BYTES` is captured.

## Operation
- Two-state FSM: IDLE and EMIT.
- **IDLE**
  - `in_ready = 1` while `rst_n = 1`.
  - On `in_valid && in_ready`, latch the message and length L, then go to EMIT.
  - If `in_len > MAX_BYTES`, L saturates to `MAX_BYTES` and `len_err` pulses on the next cycle.
- **Block count:** `nblk = floor((L+8)/64) + 1`.
- **Byte contents:** for global byte index `i = 64*idx + j`:
  - `i < L`: message byte i.
  - `i == L`: 0x80.
  - `i ≥ 64*nblk - 8`: byte `(i - (64*nblk-8))` of the 64-bit big-endian value `L*8`.
  - Otherwise: 0x00.
- **EMIT**
  - Present block `idx`.
  - On `out_valid && out_ready` with `idx < nblk-1`, increment `idx` and register the next block, with no bubble.
  - On `out_valid && out_ready` with `idx == nblk-1`, go to IDLE and clear `out_valid`.
- `in_ready = 0` throughout EMIT. One message is in flight at a time.
- **Arithmetic:** the bit length is computed as 64-bit `{L, 3'b000}` zero-extended. `out_nblk` is registered at capture.

## Timing
- **Reset:** state = IDLE, `out_valid` = 0, `out_block` = 0, `out_first` = 0, `out_last` = 0, `out_idx` = 0, `out_nblk` = 0, `len_err` = 0. `in_ready` = 0 while `rst_n` is low and 1 from the first cycle after release.
- **Latency:** an input handshake in cycle T gives `out_valid = 1` with block 0 in cycle T+1.
- **Throughput:** nblk consecutive blocks when `out_ready` is held high. The next input is accepted no earlier than the cycle after the last block's handshake, so there are nblk+1 cycles per message at minimum.
- **Stability:** while `out_valid && !out_ready`, all `out_*` outputs hold stable.
- **Independence:** `out_valid` never depends combinationally on `out_ready`, and `in_ready` depends only on state and `rst_n`.
- **Reset mid-EMIT:** the current message is dropped without completing. Outputs take reset values on the next edge.
- **Boundaries:**
  - `L mod 64 = 55` gives 0x80 and the length in the same block.
  - `L mod 64 = 56` adds a block.
  - L = 0 gives a single block.
- **Flag timing:** `out_first` and `out_last` are both high when nblk = 1.

## Test plan
- **Empty message:** L=0 → single block. Byte 0 = 0x80, all other bytes 0. First = Last = 1, nblk = 1.
- **"abc":** L=3, `in_msg` top bytes 0x616263 → block `[511:480]` = 0x61626380, low 64 bits = 0x18, nblk = 1. The downstream SHA-256 digest must equal ba7816bf…f20015ad.
- **Length sweep around block boundaries:**
  - L=55 → 1 block, length 0x1B8.
  - L=56 → 2 blocks. 0x80 at block0 byte 56; block1 is all zero except length 0x1C0.
  - L=64 → 2 blocks. 0x80 at block1 byte 0; length 0x200.
- **Maximum length:** L=1248 → nblk = 20, `out_idx` runs 0..19. 0x80 at block19 byte 32; block19 low 64 bits = 0x2700. With `out_ready` held high, one block per cycle with no bubbles.
- **Back-pressure:** random `out_ready` (~50%) on L=200 → 4 blocks, each held stable while stalled and in order. `in_ready` stays 0 until the cycle after block 3's handshake.
- **Error and reset:**
  - `in_len = MAX_BYTES+5` → `len_err` pulses once and output is identical to the L=1248 case.
  - Assert `rst_n` low during block 2 of a 4-block message → `out_valid` = 0 and state IDLE after the edge. A new L=3 message then emits correctly.
